// File: rtl/rv_iommu_wsi_pkg.sv
// Shared definitions for the IOMMU wire-signaled interrupt gateway.
//   wsi_state_e : per-vector state (IDLE, PEND, CLAIMED)
//   NO_CLAIM_ID : claim_id value returned when nothing is eligible
//   id_width()  : width of a vector id (index+1, 0 reserved for "none")
package rv_iommu_wsi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PEND    = 2'b01,
        CLAIMED = 2'b10
    } wsi_state_e;

    localparam int unsigned NO_CLAIM_ID = 0;

    function automatic int unsigned id_width(input int unsigned n_vec);
        return $clog2(n_vec) + 1;
    endfunction

endpackage

// File: rtl/rv_iommu_wsi_src.sv
// One WSI vector: wire synchroniser, rising-edge detect, saturating edge
// counter and the IDLE/PEND/CLAIMED state machine.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   wire_i           : raw interrupt wire (asynchronous to clk_i)
//   edge_mode_i      : 1 = rising-edge mode, 0 = level mode
//   claim_sel_i      : this vector is the one picked by the current claim
//   complete_sel_i   : completion strobe addressed to this vector
//   state_o          : current wsi_state_e encoding
module rv_iommu_wsi_src
    import rv_iommu_wsi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wire_i,
    input  logic       edge_mode_i,
    input  logic       claim_sel_i,
    input  logic       complete_sel_i,
    output logic [1:0] state_o
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    wsi_state_e             state_q, state_d;
    logic                   s, rise, trigger;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], wire_i};
    end

    // Counter only tracks edges in edge mode; a claim consumes one edge.
    always_comb begin
        cnt_d = cnt_q;
        if (!edge_mode_i) begin
            cnt_d = '0;
        end else if (rise && claim_sel_i) begin
            cnt_d = cnt_q;
        end else if (rise) begin
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (claim_sel_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign trigger = edge_mode_i ? (cnt_q != '0) : s;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trigger)        state_d = PEND;
            PEND:    if (claim_sel_i)    state_d = CLAIMED;
            CLAIMED: if (complete_sel_i) state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            s_d_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
        end else begin
            sync_q  <= sync_d;
            s_d_q   <= s;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/rv_iommu_wsi_gateway.sv
// Receiver for the IOMMU wire-signaled interrupt vector. Each wire gets a
// rv_iommu_wsi_src; this level adds the lowest-index-first claim encoder,
// the registered claim response and the registered hart interrupt.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   wsi_wires_i      : raw IOMMU interrupt wires
//   enable_i         : per-vector enable (masks irq and claim only)
//   edge_mode_i      : per-vector 1 = rising edge, 0 = level
//   claim_i          : claim request strobe
//   claim_valid_o    : claim response strobe, one cycle after claim_i
//   claim_id_o       : claimed index+1, 0 = none; held until next claim
//   complete_i       : completion strobe
//   complete_id_i    : index+1 of the vector being completed
//   irq_o            : registered OR of enabled pending vectors
//   pending_o        : per-vector PEND status, unmasked
module rv_iommu_wsi_gateway
    import rv_iommu_wsi_pkg::*;
#(
    parameter int unsigned N_INT_VEC   = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_INT_VEC-1:0]         wsi_wires_i,
    input  logic [N_INT_VEC-1:0]         enable_i,
    input  logic [N_INT_VEC-1:0]         edge_mode_i,
    input  logic                         claim_i,
    output logic                         claim_valid_o,
    output logic [$clog2(N_INT_VEC):0]   claim_id_o,
    input  logic                         complete_i,
    input  logic [$clog2(N_INT_VEC):0]   complete_id_i,
    output logic                         irq_o,
    output logic [N_INT_VEC-1:0]         pending_o
);

    localparam int unsigned IdW = id_width(N_INT_VEC);

    logic [N_INT_VEC-1:0] pend, elig, claim_sel, complete_sel;
    logic [IdW-1:0]       sel_id;
    logic                 claim_valid_q, claim_valid_d;
    logic [IdW-1:0]       claim_id_q, claim_id_d;
    logic                 irq_q, irq_d;

    for (genvar g = 0; g < N_INT_VEC; g++) begin : g_src
        logic [1:0] state;

        assign complete_sel[g] = complete_i && (complete_id_i == IdW'(g + 1));

        rv_iommu_wsi_src #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
        ) u_src (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .wire_i         (wsi_wires_i[g]),
            .edge_mode_i    (edge_mode_i[g]),
            .claim_sel_i    (claim_sel[g]),
            .complete_sel_i (complete_sel[g]),
            .state_o        (state)
        );

        assign pend[g] = (state == PEND);
    end

    assign elig = pend & enable_i;

    // Lowest eligible index wins.
    always_comb begin
        logic found;
        found     = 1'b0;
        sel_id    = IdW'(NO_CLAIM_ID);
        claim_sel = '0;
        for (int i = 0; i < N_INT_VEC; i++) begin
            if (elig[i] && !found) begin
                found        = 1'b1;
                sel_id       = IdW'(i + 1);
                claim_sel[i] = claim_i;
            end
        end
    end

    always_comb begin
        claim_valid_d = claim_i;
        claim_id_d    = claim_i ? sel_id : claim_id_q;
        irq_d         = |elig;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            claim_valid_q <= 1'b0;
            claim_id_q    <= '0;
            irq_q         <= 1'b0;
        end else begin
            claim_valid_q <= claim_valid_d;
            claim_id_q    <= claim_id_d;
            irq_q         <= irq_d;
        end
    end

    assign claim_valid_o = claim_valid_q;
    assign claim_id_o    = claim_id_q;
    assign irq_o         = irq_q;
    assign pending_o     = pend;

endmodule
